hazard_detect: RTL and testbench
================================

# hazard_detect

Upstream hazard/exception front-end for `pipeline_ctrl`. It watches the ID, EX and MEM stages and produces the registered `pval`, `opcode` and `ctrl` inputs that `pipeline_ctrl` samples on the falling clock edge. It tracks multi-cycle EX operations (MUL/DIV) with a down-counter, holding `pval` low while one is in flight. It latches sticky exception causes until the trap handler acknowledges them.

## Interface

Parameters:
- `OP_MUL`, default 6'h18, opcode of the multi-cycle multiply.
- `OP_DIV`, default 6'h1A, opcode of the multi-cycle divide.
- `MUL_CYCLES`, default 3, EX occupancy of MUL in cycles; legal range 1..16.
- `DIV_CYCLES`, default 8, EX occupancy of DIV in cycles; legal range 1..16.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  a valid instruction occupies ID this cycle.
- `id_opcode`  in  6  opcode of the ID instruction.
- `id_illegal`  in  1  decoder flags the ID opcode as illegal; qualified by `id_valid`.
- `ex_divzero`  in  1  EX divider detected a zero divisor (single-cycle pulse).
- `mem_lsq_full`  in  1  load/store queue full (level).
- `exc_ack`  in  1  trap handler entry; clears latched exception causes (single-cycle pulse).
- `pval`  out  1  1 = pipeline may advance, evaluate `ctrl`/`opcode`; 0 = hold/bubble.
- `opcode`  out  6  opcode presented to `pipeline_ctrl`.
- `ctrl`  out  3  bit0 illegal (sticky), bit1 divide-by-zero (sticky), bit2 LSQ full (live, registered).
- `mc_busy`  out  1  a multi-cycle operation occupies EX.

## Operation

- FSM states: IDLE, MULTI, TRAP. A 4-bit down-counter `cnt` and the sticky bits `ctrl[1:0]` are state.
- Reset (async, immediate): state IDLE, `cnt`=0, `pval`=1, `opcode`=0, `ctrl`=3'b000, `mc_busy`=0.
- `ctrl[2]` <= `mem_lsq_full` every cycle in every state. It is not sticky and is not cleared by `exc_ack`.
- Sticky set: `ctrl[0]` <= 1 on `id_valid & id_illegal`; `ctrl[1]` <= 1 on `ex_divzero`.
- Sticky clear: `exc_ack` clears `ctrl[1:0]`. A set and an `exc_ack` in the same cycle: set wins for that bit.
- IDLE:
  - If a sticky cause is set this cycle, go to TRAP.
  - Otherwise, if `id_valid` and `id_opcode` is `OP_MUL` or `OP_DIV` (and not illegal): load `cnt` = CYCLES-1, latch `opcode` <= `id_opcode`, set `pval`<=0 and `mc_busy`<=1, go to MULTI.
  - Otherwise: `opcode` <= `id_valid ? id_opcode : 0`, `pval`<=1.
- MULTI:
  - `opcode` is held.
  - If `cnt`==0: `pval`<=1, `mc_busy`<=0, go to IDLE.
  - Otherwise: `cnt` decrements, `pval` stays 0.
  - A CYCLES=1 op spends exactly one cycle in MULTI.
- TRAP (entered from any state when a sticky bit gets set):
  - `pval`<=1 so `pipeline_ctrl` sees `ctrl`.
  - Any in-flight multi-cycle op is aborted: `cnt`<=0, `mc_busy`<=0.
  - `opcode` <= 0.
  - Stay in TRAP until `exc_ack` with no simultaneous new cause, then go to IDLE.
  - New MUL/DIV in ID is ignored while in TRAP.
- Priority per cycle: reset > exception set > multi-cycle completion > new multi-cycle start.

## Timing

- All outputs are registered. Latency is one rising edge from input to output.
- `pipeline_ctrl` samples on the falling edge, so outputs are stable half a cycle before use.
- MUL issued at edge N: `pval` is 0 for edges N..N+MUL_CYCLES-1 and returns to 1 at edge N+MUL_CYCLES.
- `ex_divzero` at edge N: `ctrl[1]`=1 and `pval`=1 from edge N, even mid-DIV.
- `exc_ack` at edge N with no new cause: `ctrl[1:0]`=0 and state IDLE after edge N.
- Back-to-back MUL/DIV: the second op is accepted on the edge where the first completes only if presented while state is IDLE, i.e. the cycle after completion. There is no overlap.

## Test plan

- Reset asserted mid-DIV with `cnt`=5 → outputs go immediately to `pval`=1, `ctrl`=000, `opcode`=0, `mc_busy`=0, with no clock edge needed.
- `id_valid`=1, `id_opcode`=6'h18, MUL_CYCLES=3 → `pval`=0 for exactly 3 cycles, `opcode`=6'h18 throughout, `mc_busy`=0 and `pval`=1 on the 4th edge.
- DIV issued, then `ex_divzero` pulsed on its 4th cycle → `ctrl`=3'b010, `pval`=1, `mc_busy`=0 next edge. State remains TRAP until `exc_ack`, after which `ctrl`=000.
- `id_illegal` and `exc_ack` asserted together while in TRAP with `ctrl[1]`=1 → `ctrl[0]`=1, `ctrl[1]`=0, state remains TRAP.
- `mem_lsq_full` toggled 1,0,1 during IDLE and during MULTI → `ctrl[2]` follows one edge later. FSM state and `pval` are unaffected.
- DIV_CYCLES=1 and MUL_CYCLES=16 → `pval` low for exactly 1 and 16 cycles respectively, with no counter wrap.

Source files
------------

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - hazard/exception front-end producing pval/opcode/ctrl for pipeline_ctrl
module hazard_detect #(
  parameter logic [5:0] OP_MUL     = 6'h18,
  parameter logic [5:0] OP_DIV     = 6'h1A,
  parameter int         MUL_CYCLES = 3,
  parameter int         DIV_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [5:0] id_opcode,
  input  logic       id_illegal,
  input  logic       ex_divzero,
  input  logic       mem_lsq_full,
  input  logic       exc_ack,
  output logic       pval,
  output logic [5:0] opcode,
  output logic [2:0] ctrl,
  output logic       mc_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULTI = 2'd1,
    TRAP  = 2'd2
  } state_t;

  // Counter load values: the op occupies EX for CYCLES edges, the last one seeing cnt==0.
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;

  logic set_ill;
  logic set_dz;
  logic set_any;
  logic is_mul;
  logic is_div;
  logic start_mc;

  assign set_ill  = id_valid & id_illegal;
  assign set_dz   = ex_divzero;
  assign set_any  = set_ill | set_dz;
  assign is_mul   = (id_opcode == OP_MUL);
  assign is_div   = (id_opcode == OP_DIV);
  assign start_mc = id_valid & (is_mul | is_div);

  // Sticky causes: a new cause beats a simultaneous acknowledge; LSQ full is a plain registered copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl <= 3'b000;
    end else begin
      ctrl[0] <= set_ill | (ctrl[0] & ~exc_ack);
      ctrl[1] <= set_dz  | (ctrl[1] & ~exc_ack);
      ctrl[2] <= mem_lsq_full;
    end
  end

  // Control FSM: exception entry outranks multi-cycle completion, which outranks a new start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      pval    <= 1'b1;
      opcode  <= 6'd0;
      mc_busy <= 1'b0;
    end else if (set_any) begin
      state   <= TRAP;
      cnt     <= 4'd0;
      pval    <= 1'b1;
      opcode  <= 6'd0;
      mc_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_mc) begin
            cnt     <= is_mul ? MUL_LOAD : DIV_LOAD;
            opcode  <= id_opcode;
            pval    <= 1'b0;
            mc_busy <= 1'b1;
            state   <= MULTI;
          end else begin
            opcode  <= id_valid ? id_opcode : 6'd0;
            pval    <= 1'b1;
          end
        end
        MULTI: begin
          if (cnt == 4'd0) begin
            pval    <= 1'b1;
            mc_busy <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt     <= cnt - 4'd1;
            pval    <= 1'b0;
          end
        end
        TRAP: begin
          pval    <= 1'b1;
          opcode  <= 6'd0;
          cnt     <= 4'd0;
          mc_busy <= 1'b0;
          if (exc_ack) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= 4'd0;
          pval    <= 1'b1;
          opcode  <= 6'd0;
          mc_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_detect.sv
// tb/tb_hazard_detect.sv - self-checking bench for hazard_detect (two parameterisations)
module tb_hazard_detect;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [5:0] id_opcode;
  logic       id_illegal;
  logic       ex_divzero;
  logic       mem_lsq_full;
  logic       exc_ack;

  logic       pv  [2];
  logic [5:0] opc [2];
  logic [2:0] ct  [2];
  logic       bz  [2];

  int n_cmp;
  int n_bad;

  // Reference model state per instance
  int         mcyc [2];
  int         dcyc [2];
  int         rem  [2];
  bit         trap [2];
  logic [2:0] mct  [2];
  logic [5:0] mop  [2];
  logic       mpv  [2];

  hazard_detect u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_illegal(id_illegal), .ex_divzero(ex_divzero), .mem_lsq_full(mem_lsq_full),
    .exc_ack(exc_ack), .pval(pv[0]), .opcode(opc[0]), .ctrl(ct[0]), .mc_busy(bz[0])
  );

  hazard_detect #(.MUL_CYCLES(16), .DIV_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_illegal(id_illegal), .ex_divzero(ex_divzero), .mem_lsq_full(mem_lsq_full),
    .exc_ack(exc_ack), .pval(pv[1]), .opcode(opc[1]), .ctrl(ct[1]), .mc_busy(bz[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      rem[i] = 0; trap[i] = 0; mct[i] = 3'b000; mop[i] = 6'd0; mpv[i] = 1'b1;
    end
  endtask

  // Behavioural rules: remaining-occupancy count, trap flag, sticky bits.
  task automatic model_edge();
    bit s0, s1;
    s0 = id_valid & id_illegal;
    s1 = ex_divzero;
    for (int i = 0; i < 2; i++) begin
      mct[i][0] = s0 | (mct[i][0] & ~exc_ack);
      mct[i][1] = s1 | (mct[i][1] & ~exc_ack);
      mct[i][2] = mem_lsq_full;
      if (s0 || s1) begin
        trap[i] = 1; rem[i] = 0; mpv[i] = 1'b1; mop[i] = 6'd0;
      end else if (trap[i]) begin
        mop[i] = 6'd0; mpv[i] = 1'b1;
        if (exc_ack) trap[i] = 0;
      end else if (rem[i] > 0) begin
        rem[i] = rem[i] - 1;
        mpv[i] = (rem[i] == 0);
      end else if (id_valid && (id_opcode == 6'h18 || id_opcode == 6'h1A)) begin
        rem[i] = (id_opcode == 6'h18) ? mcyc[i] : dcyc[i];
        mop[i] = id_opcode;
        mpv[i] = 1'b0;
      end else begin
        mop[i] = id_valid ? id_opcode : 6'd0;
        mpv[i] = 1'b1;
      end
    end
  endtask

  task automatic step(input logic v, input logic [5:0] op, input logic ill,
                      input logic dz, input logic lsq, input logic ack);
    id_valid = v; id_opcode = op; id_illegal = ill;
    ex_divzero = dz; mem_lsq_full = lsq; exc_ack = ack;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (pv[i] !== 1'b1 || opc[i] !== 6'd0 || ct[i] !== 3'b000 || bz[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset[%0d] got pval=%0b op=%h ctrl=%b busy=%0b exp 1/00/000/0",
                 i, pv[i], opc[i], ct[i], bz[i]);
      end
    end
  endtask

  task automatic test_mul();
    logic       sp0 [20];
    logic       sp1 [20];
    logic       sb0 [20];
    logic [5:0] so0 [20];
    int lz0, lz1;
    step(1, 6'h18, 0, 0, 0, 0);
    sp0[0] = pv[0]; sp1[0] = pv[1]; sb0[0] = bz[0]; so0[0] = opc[0];
    for (int k = 1; k < 20; k++) begin
      step(0, 6'h00, 0, 0, 0, 0);
      sp0[k] = pv[0]; sp1[k] = pv[1]; sb0[k] = bz[0]; so0[k] = opc[0];
    end
    lz0 = 0; while (lz0 < 20 && sp0[lz0] == 1'b0) lz0++;
    lz1 = 0; while (lz1 < 20 && sp1[lz1] == 1'b0) lz1++;
    n_cmp++;
    if (lz0 != 3) begin n_bad++; $display("FAIL mul3_low got=%0d exp=3", lz0); end
    n_cmp++;
    if (lz1 != 16) begin n_bad++; $display("FAIL mul16_low got=%0d exp=16", lz1); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (so0[k] !== 6'h18 || sb0[k] !== 1'b1) begin
        n_bad++; $display("FAIL mul3_hold[%0d] got op=%h busy=%0b exp 18/1", k, so0[k], sb0[k]);
      end
    end
    n_cmp++;
    if (sb0[3] !== 1'b0 || sp0[3] !== 1'b1) begin
      n_bad++; $display("FAIL mul3_done got busy=%0b pval=%0b exp 0/1", sb0[3], sp0[3]);
    end
  endtask

  task automatic test_div_lengths();
    int lz0, lz1;
    logic s0, s1;
    bit c0, c1;
    lz0 = 0; lz1 = 0; c0 = 1; c1 = 1;
    step(1, 6'h1A, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      s0 = pv[0]; s1 = pv[1];
      if (c0 && s0 == 1'b0) lz0++; else c0 = 0;
      if (c1 && s1 == 1'b0) lz1++; else c1 = 0;
      step(0, 6'h00, 0, 0, 0, 0);
    end
    n_cmp++;
    if (lz0 != 8) begin n_bad++; $display("FAIL div8_low got=%0d exp=8", lz0); end
    n_cmp++;
    if (lz1 != 1) begin n_bad++; $display("FAIL div1_low got=%0d exp=1", lz1); end
  endtask

  task automatic test_divzero();
    step(1, 6'h1A, 0, 0, 0, 0);
    step(0, 6'h00, 0, 0, 0, 0);
    step(0, 6'h00, 0, 0, 0, 0);
    step(0, 6'h00, 0, 1, 0, 0);
    n_cmp++;
    if (ct[0] !== 3'b010 || pv[0] !== 1'b1 || bz[0] !== 1'b0) begin
      n_bad++; $display("FAIL divzero_entry got ctrl=%b pval=%0b busy=%0b exp 010/1/0", ct[0], pv[0], bz[0]);
    end
    for (int k = 0; k < 3; k++) begin
      step(1, 6'h18, 0, 0, 0, 0);
      n_cmp++;
      if (ct[0] !== 3'b010 || bz[0] !== 1'b0 || opc[0] !== 6'd0 || pv[0] !== 1'b1) begin
        n_bad++; $display("FAIL trap_hold[%0d] got ctrl=%b busy=%0b op=%h pval=%0b exp 010/0/00/1",
                          k, ct[0], bz[0], opc[0], pv[0]);
      end
    end
    step(0, 6'h00, 0, 0, 0, 1);
    n_cmp++;
    if (ct[0] !== 3'b000) begin n_bad++; $display("FAIL divzero_ack got ctrl=%b exp 000", ct[0]); end
    step(1, 6'h18, 0, 0, 0, 0);
    n_cmp++;
    if (bz[0] !== 1'b1 || pv[0] !== 1'b0) begin
      n_bad++; $display("FAIL post_ack_start got busy=%0b pval=%0b exp 1/0", bz[0], pv[0]);
    end
    for (int k = 0; k < 4; k++) step(0, 6'h00, 0, 0, 0, 0);
  endtask

  task automatic test_illegal_ack();
    step(0, 6'h00, 0, 1, 0, 0);
    step(1, 6'h05, 1, 0, 0, 1);
    n_cmp++;
    if (ct[0] !== 3'b001 || ct[1] !== 3'b001) begin
      n_bad++; $display("FAIL ill_ack got ctrl0=%b ctrl1=%b exp 001", ct[0], ct[1]);
    end
    step(1, 6'h05, 0, 0, 0, 0);
    n_cmp++;
    if (opc[0] !== 6'd0 || ct[0] !== 3'b001) begin
      n_bad++; $display("FAIL ill_stay_trap got op=%h ctrl=%b exp 00/001", opc[0], ct[0]);
    end
    step(0, 6'h00, 0, 0, 0, 1);
    step(1, 6'h05, 0, 0, 0, 0);
    n_cmp++;
    if (opc[0] !== 6'h05 || ct[0] !== 3'b000) begin
      n_bad++; $display("FAIL ill_exit got op=%h ctrl=%b exp 05/000", opc[0], ct[0]);
    end
  endtask

  task automatic test_lsq();
    logic pat [3];
    pat[0] = 1; pat[1] = 0; pat[2] = 1;
    for (int k = 0; k < 3; k++) begin
      step(0, 6'h00, 0, 0, pat[k], 0);
      n_cmp++;
      if (ct[0][2] !== pat[k] || pv[0] !== 1'b1 || bz[0] !== 1'b0) begin
        n_bad++; $display("FAIL lsq_idle[%0d] got lsq=%0b pval=%0b exp %0b/1", k, ct[0][2], pv[0], pat[k]);
      end
    end
    step(1, 6'h1A, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 6'h00, 0, 0, pat[k], 0);
      n_cmp++;
      if (ct[0][2] !== pat[k] || pv[0] !== 1'b0 || bz[0] !== 1'b1 || ct[0][1:0] !== 2'b00) begin
        n_bad++; $display("FAIL lsq_multi[%0d] got ctrl=%b pval=%0b busy=%0b exp %0b00/0/1",
                          k, ct[0], pv[0], bz[0], pat[k]);
      end
    end
    for (int k = 0; k < 6; k++) step(0, 6'h00, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic exp_seq [8];
    exp_seq = '{0, 0, 0, 1, 0, 0, 0, 1};
    for (int k = 0; k < 8; k++) begin
      step(1, 6'h18, 0, 0, 0, 0);
      n_cmp++;
      if (pv[0] !== exp_seq[k]) begin
        n_bad++; $display("FAIL b2b[%0d] got pval=%0b exp=%0b", k, pv[0], exp_seq[k]);
      end
    end
    for (int k = 0; k < 20; k++) step(0, 6'h00, 0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    step(1, 6'h1A, 0, 0, 1, 0);
    step(0, 6'h00, 0, 0, 1, 0);
    step(0, 6'h00, 0, 0, 1, 0);
    n_cmp++;
    if (bz[0] !== 1'b1 || ct[0][2] !== 1'b1) begin
      n_bad++; $display("FAIL areset_pre got busy=%0b lsq=%0b exp 1/1", bz[0], ct[0][2]);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (pv[0] !== 1'b1 || ct[0] !== 3'b000 || opc[0] !== 6'd0 || bz[0] !== 1'b0) begin
      n_bad++; $display("FAIL areset got pval=%0b ctrl=%b op=%h busy=%0b exp 1/000/00/0",
                        pv[0], ct[0], opc[0], bz[0]);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] op;
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 3))
        0: op = 6'h18;
        1: op = 6'h1A;
        default: op = 6'($urandom_range(0, 63));
      endcase
      step(1'($urandom_range(0, 1)), op, ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (pv[i] !== mpv[i] || opc[i] !== mop[i] || ct[i] !== mct[i] || bz[i] !== (rem[i] > 0)) begin
          n_bad++;
          $display("FAIL rand[%0d][%0d] got pval=%0b op=%h ctrl=%b busy=%0b exp %0b/%h/%b/%0b",
                   k, i, pv[i], opc[i], ct[i], bz[i], mpv[i], mop[i], mct[i], (rem[i] > 0));
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    mcyc[0] = 3; mcyc[1] = 16;
    dcyc[0] = 8; dcyc[1] = 1;
    model_reset();
    rst = 1'b1;
    id_valid = 0; id_opcode = 0; id_illegal = 0;
    ex_divzero = 0; mem_lsq_full = 0; exc_ack = 0;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_mul();
    test_div_lengths();
    test_divzero();
    test_illegal_ack();
    test_lsq();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
